// File: rtl/vx_ipdom_warp_stack.sv
// Per-warp IPDOM reconvergence stack bank.
// NUM_WARPS independent LIFOs share one data RAM addressed {wid, slot}. Each entry
// holds a {q2,q1} pair plus a part bit:
//   part=0 -> the next pop returns q2 and only marks the entry half-consumed.
//   part=1 -> the next pop returns q1 and releases the entry.
// A non-split push sets part=1 at write time, so that entry pops once.
module vx_ipdom_warp_stack #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int NUM_WARPS = 4,
    parameter int WIDW      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int CNTW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [WIDW-1:0]  push_wid,
    input  logic             push_pair,
    input  logic [WIDTH-1:0] push_q1,
    input  logic [WIDTH-1:0] push_q2,
    input  logic             pop_valid,
    input  logic [WIDW-1:0]  pop_wid,
    input  logic [WIDW-1:0]  rd_wid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_index,
    output logic             rd_empty,
    output logic             rd_full,
    output logic [CNTW-1:0]  rd_count,
    input  logic             err_clr,
    output logic [2:0]       err_flags
);

    localparam int SLOTW = $clog2(DEPTH);

    logic [CNTW-1:0]  count_q [NUM_WARPS];
    logic [DEPTH-1:0] part_q  [NUM_WARPS];
    logic [WIDTH-1:0] q1_mem  [NUM_WARPS][DEPTH];
    logic [WIDTH-1:0] q2_mem  [NUM_WARPS][DEPTH];

    logic [CNTW-1:0]  push_cnt;
    logic [CNTW-1:0]  pop_cnt;
    logic [SLOTW-1:0] push_slot;
    logic [SLOTW-1:0] pop_top;
    logic             push_full;
    logic             pop_empty;
    logic             same_warp;
    logic             push_ok;
    logic             pop_ok;
    logic             pop_part;
    logic [2:0]       new_err;

    logic [CNTW-1:0]  rd_cnt;
    logic [SLOTW-1:0] rd_top;

    // Request qualification. The push slot always fits SLOTW bits because a
    // push is only accepted below DEPTH; the pop top is only used when non-empty.
    always_comb begin
        push_cnt  = count_q[push_wid];
        pop_cnt   = count_q[pop_wid];
        push_slot = SLOTW'(push_cnt);
        pop_top   = SLOTW'(pop_cnt - CNTW'(1));
        push_full = (push_cnt == CNTW'(DEPTH));
        pop_empty = (pop_cnt == '0);
        // A same-warp pop is dropped so the push sees a stable top slot.
        same_warp = push_valid && pop_valid && (push_wid == pop_wid);
        push_ok   = push_valid && !push_full;
        pop_ok    = pop_valid && !same_warp && !pop_empty;
        pop_part  = part_q[pop_wid][pop_top];
        new_err   = {same_warp,
                     pop_valid && !same_warp && pop_empty,
                     push_valid && push_full};
    end

    // Counts, part bits and sticky error flags; push and pop only both commit
    // when they target different warps, so their writes never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                count_q[w] <= '0;
                part_q[w]  <= '0;
            end
            err_flags <= '0;
        end else begin
            if (push_ok) begin
                count_q[push_wid]           <= push_cnt + CNTW'(1);
                part_q[push_wid][push_slot] <= ~push_pair;
            end
            if (pop_ok) begin
                if (pop_part) begin
                    count_q[pop_wid] <= pop_cnt - CNTW'(1);
                end else begin
                    part_q[pop_wid][pop_top] <= 1'b1;
                end
            end
            err_flags <= (err_clr ? 3'b000 : err_flags) | new_err;
        end
    end

    // Data RAM write port; contents are never reset, only the counts guard reads.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            q1_mem[push_wid][push_slot] <= push_q1;
            q2_mem[push_wid][push_slot] <= push_q2;
        end
    end

    // Zero-latency top-of-stack view of rd_wid from registered state.
    always_comb begin
        rd_cnt   = count_q[rd_wid];
        rd_top   = SLOTW'(rd_cnt - CNTW'(1));
        rd_count = rd_cnt;
        rd_empty = (rd_cnt == '0);
        rd_full  = (rd_cnt == CNTW'(DEPTH));
        rd_index = !rd_empty && part_q[rd_wid][rd_top];
        if (rd_empty) begin
            rd_data = '0;
        end else if (rd_index) begin
            rd_data = q1_mem[rd_wid][rd_top];
        end else begin
            rd_data = q2_mem[rd_wid][rd_top];
        end
    end

endmodule

// File: tb/tb_vx_ipdom_warp_stack.sv
// Bench for vx_ipdom_warp_stack: directed scenarios plus randomized traffic,
// checked against a value-level model (each warp is a queue of pending pop values).
module tb_vx_ipdom_warp_stack;

    localparam int W = 32;
    localparam int D = 8;
    localparam int N = 4;

    logic          clk;
    logic          reset;
    logic          push_valid;
    logic [1:0]    push_wid;
    logic          push_pair;
    logic [W-1:0]  push_q1;
    logic [W-1:0]  push_q2;
    logic          pop_valid;
    logic [1:0]    pop_wid;
    logic [1:0]    rd_wid;
    logic [W-1:0]  rd_data;
    logic          rd_index;
    logic          rd_empty;
    logic          rd_full;
    logic [3:0]    rd_count;
    logic          err_clr;
    logic [2:0]    err_flags;

    int total = 0;
    int bad   = 0;

    // Model: every pending pop is one element; rel=1 marks the pop that frees an entry.
    typedef struct packed {
        logic [W-1:0] v;
        logic         rel;
    } ent_t;

    ent_t       mstk [N][$];
    int         mcnt [N];
    logic [2:0] merr;

    vx_ipdom_warp_stack #(.WIDTH(W), .DEPTH(D), .NUM_WARPS(N)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_wid(push_wid), .push_pair(push_pair),
        .push_q1(push_q1), .push_q2(push_q2),
        .pop_valid(pop_valid), .pop_wid(pop_wid),
        .rd_wid(rd_wid), .rd_data(rd_data), .rd_index(rd_index),
        .rd_empty(rd_empty), .rd_full(rd_full), .rd_count(rd_count),
        .err_clr(err_clr), .err_flags(err_flags)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic model_clear();
        for (int w = 0; w < N; w++) begin
            mstk[w].delete();
            mcnt[w] = 0;
        end
        merr = 3'b000;
    endtask

    // Drive one request cycle, advance the model, then return 1 time unit after the edge.
    task automatic cyc(input bit pv, input int pw, input bit pp, input logic [W-1:0] a1,
                       input logic [W-1:0] a2, input bit ov, input int ow, input bit clr);
        bit         same;
        logic [2:0] ne;
        ent_t       e;
        push_valid = pv; push_wid = 2'(pw); push_pair = pp; push_q1 = a1; push_q2 = a2;
        pop_valid = ov; pop_wid = 2'(ow); err_clr = clr;
        ne = 3'b000;
        same = pv && ov && (pw == ow);
        if (ov) begin
            if (same) ne[2] = 1'b1;
            else if (mstk[ow].size() == 0) ne[1] = 1'b1;
            else begin
                e = mstk[ow].pop_back();
                if (e.rel) mcnt[ow]--;
            end
        end
        if (pv) begin
            if (mcnt[pw] == D) ne[0] = 1'b1;
            else begin
                e.v = a1; e.rel = 1'b1; mstk[pw].push_back(e);
                if (pp) begin
                    e.v = a2; e.rel = 1'b0; mstk[pw].push_back(e);
                end
                mcnt[pw]++;
            end
        end
        merr = (clr ? 3'b000 : merr) | ne;
        @(posedge clk); #1;
        push_valid = 0; pop_valid = 0; err_clr = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        model_clear();
        for (int w = 0; w < N; w++) begin
            rd_wid = 2'(w); #1;
            total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL reset_empty w%0d got=%b exp=1", w, rd_empty); end
            total++; if (rd_count !== 4'd0) begin bad++; $display("FAIL reset_count w%0d got=%0d exp=0", w, rd_count); end
            total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_data w%0d got=%h exp=0", w, rd_data); end
            total++; if (rd_index !== 1'b0 || rd_full !== 1'b0) begin bad++; $display("FAIL reset_idx_full w%0d got=%b%b exp=00", w, rd_index, rd_full); end
        end
        total++; if (err_flags !== 3'b000) begin bad++; $display("FAIL reset_err got=%b exp=000", err_flags); end
    endtask

    task automatic test_pair();
        rd_wid = 2'd1;
        cyc(1, 1, 1, 32'hA, 32'hB, 0, 0, 0);
        total++; if (rd_data !== 32'hB || rd_index !== 1'b0 || rd_count !== 4'd1) begin bad++;
            $display("FAIL pair_push got=%h/%b/%0d exp=b/0/1", rd_data, rd_index, rd_count); end
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        total++; if (rd_data !== 32'hA || rd_index !== 1'b1 || rd_count !== 4'd1) begin bad++;
            $display("FAIL pair_pop1 got=%h/%b/%0d exp=a/1/1", rd_data, rd_index, rd_count); end
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        total++; if (rd_empty !== 1'b1 || rd_count !== 4'd0 || rd_data !== '0) begin bad++;
            $display("FAIL pair_pop2 got=%b/%0d/%h exp=1/0/0", rd_empty, rd_count, rd_data); end
    endtask

    task automatic test_overflow();
        rd_wid = 2'd0;
        for (int i = 1; i <= D; i++) cyc(1, 0, 0, 32'(i), 32'hDEAD, 0, 0, 0);
        total++; if (rd_full !== 1'b1 || rd_data !== 32'd8 || rd_count !== 4'd8) begin bad++;
            $display("FAIL ovf_fill got=%b/%h/%0d exp=1/8/8", rd_full, rd_data, rd_count); end
        cyc(1, 0, 0, 32'd9, 32'd0, 0, 0, 0);
        total++; if (err_flags !== 3'b001) begin bad++; $display("FAIL ovf_flag got=%b exp=001", err_flags); end
        total++; if (rd_data !== 32'd8 || rd_count !== 4'd8) begin bad++;
            $display("FAIL ovf_drop got=%h/%0d exp=8/8", rd_data, rd_count); end
        for (int i = D; i >= 1; i--) begin
            total++; if (rd_data !== 32'(i)) begin bad++; $display("FAIL ovf_pop got=%h exp=%h", rd_data, 32'(i)); end
            cyc(0, 0, 0, 0, 0, 1, 0, 0);
        end
        total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL ovf_drain got=%b exp=1", rd_empty); end
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        total++; if (err_flags !== 3'b000) begin bad++; $display("FAIL ovf_clr got=%b exp=000", err_flags); end
    endtask

    task automatic test_diff_warps();
        cyc(1, 3, 0, 32'h7, 32'h0, 0, 0, 0);
        cyc(1, 2, 0, 32'h5, 32'h0, 1, 3, 0);
        rd_wid = 2'd2; #1;
        total++; if (rd_count !== 4'd1 || rd_data !== 32'h5) begin bad++;
            $display("FAIL diff_w2 got=%0d/%h exp=1/5", rd_count, rd_data); end
        rd_wid = 2'd3; #1;
        total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL diff_w3 got=%b exp=1", rd_empty); end
        total++; if (err_flags !== 3'b000) begin bad++; $display("FAIL diff_err got=%b exp=000", err_flags); end
    endtask

    task automatic test_conflict();
        rd_wid = 2'd0;
        cyc(1, 0, 0, 32'h11, 32'h0, 0, 0, 0);
        cyc(1, 0, 0, 32'h22, 32'h0, 1, 0, 0);
        total++; if (rd_count !== 4'd2 || rd_data !== 32'h22) begin bad++;
            $display("FAIL conf_state got=%0d/%h exp=2/22", rd_count, rd_data); end
        total++; if (err_flags !== 3'b100) begin bad++; $display("FAIL conf_flag got=%b exp=100", err_flags); end
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        total++; if (err_flags !== 3'b000) begin bad++; $display("FAIL conf_clr got=%b exp=000", err_flags); end
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        total++; if (err_flags !== 3'b010) begin bad++; $display("FAIL udf_flag got=%b exp=010", err_flags); end
        cyc(0, 0, 0, 0, 0, 1, 1, 1);
        total++; if (err_flags !== 3'b010) begin bad++; $display("FAIL set_wins got=%b exp=010", err_flags); end
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        int   w;
        ent_t e;
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 99) < 55, $urandom_range(0, N - 1), $urandom_range(0, 2) == 0,
                $urandom, $urandom, $urandom_range(0, 99) < 45, $urandom_range(0, N - 1),
                $urandom_range(0, 15) == 0);
            w = $urandom_range(0, N - 1);
            rd_wid = 2'(w); #1;
            total++; if (rd_count !== 4'(mcnt[w]) || rd_full !== (mcnt[w] == D) || rd_empty !== (mcnt[w] == 0)) begin bad++;
                $display("FAIL rnd_count n%0d w%0d got=%0d/%b/%b exp=%0d", n, w, rd_count, rd_full, rd_empty, mcnt[w]); end
            if (mstk[w].size() == 0) begin
                e.v = '0; e.rel = 1'b0;
            end else begin
                e = mstk[w][mstk[w].size() - 1];
            end
            total++; if (rd_data !== e.v || rd_index !== e.rel) begin bad++;
                $display("FAIL rnd_top n%0d w%0d got=%h/%b exp=%h/%b", n, w, rd_data, rd_index, e.v, e.rel); end
            total++; if (err_flags !== merr) begin bad++;
                $display("FAIL rnd_err n%0d got=%b exp=%b", n, err_flags, merr); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < N; w++) cyc(1, w, i[0], 32'(16 * w + i), 32'(256 + w), 0, 0, 0);
        reset = 1; push_valid = 1; push_wid = 2'd0; push_q1 = 32'h99; push_pair = 0;
        @(posedge clk); #1;
        reset = 0; push_valid = 0;
        model_clear();
        for (int w = 0; w < N; w++) begin
            rd_wid = 2'(w); #1;
            total++; if (rd_count !== 4'd0 || rd_empty !== 1'b1) begin bad++;
                $display("FAIL rstmid_count w%0d got=%0d exp=0", w, rd_count); end
        end
        total++; if (err_flags !== 3'b000) begin bad++; $display("FAIL rstmid_err got=%b exp=000", err_flags); end
        test_pair();
    endtask

    initial begin
        reset = 1; push_valid = 0; push_wid = 0; push_pair = 0; push_q1 = 0; push_q2 = 0;
        pop_valid = 0; pop_wid = 0; rd_wid = 0; err_clr = 0;
        model_clear();
        test_reset();
        test_pair();
        test_overflow();
        test_diff_warps();
        test_conflict();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
